round_controller: RTL and testbench
===================================

ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 SHALL have parameter MAX_HEALTH, default 4'd3: health loaded at each round start.
REQ-002 SHALL have parameter ROUNDS_TO_WIN, default 2: round wins that end the match (legal range 1..3).
REQ-003 SHALL have parameter COUNTDOWN_TICKS, default 180: pre-round countdown length in ticks.
REQ-004 SHALL have parameter ROUND_TICKS, default 3600: round time limit in ticks (12-bit).
REQ-005 SHALL have parameter KO_TICKS, default 120: post-round freeze length in ticks.
REQ-006 SHALL have the following ports:
- clk  input  1: the only clock.
- reset  input  1: asynchronous, active-high reset.
- tick  input  1: one-cycle frame strobe.
- start  input  1: one-cycle start-button pulse.
- player1_status  input  4: player 1 status code; 4'd9 = hitstun.
- player2_status  input  4: player 2 status code; 4'd9 = hitstun.
- player1_health  output  4: player 1 remaining health.
- player2_health  output  4: player 2 remaining health.
- player1_rounds  output  2: player 1 round wins.
- player2_rounds  output  2: player 2 round wins.
- phase  output  3: IDLE=0, COUNTDOWN=1, FIGHT=2, KO=3, MATCH_OVER=4.
- fight_enable  output  1: high only in FIGHT.
- round_timer  output  12: remaining round ticks.
- winner  output  2: 0 none, 1 player 1, 2 player 2, 3 draw.

Function
REQ-007 SHALL detect a hit per player as a rising edge of (status==4'd9), with the previous-value register sampled on every clk edge, independent of state; all logic SHALL be clocked by clk only.
REQ-008 SHALL decrement a player's health by 1 on that player's hit only when phase==FIGHT in the same cycle. Health SHALL saturate at 0. Simultaneous hits on both players SHALL decrement both in the same cycle.
REQ-009 IDLE: on start, SHALL go to COUNTDOWN, load both healths with MAX_HEALTH, clear both round counts, set winner=0, and load the countdown counter.
REQ-010 COUNTDOWN: SHALL hold healths at MAX_HEALTH, hold round_timer at ROUND_TICKS, and decrement the counter on tick. On the tick that exhausts COUNTDOWN_TICKS it SHALL enter FIGHT on the next cycle.
REQ-011 FIGHT: round_timer SHALL decrement by 1 per tick, saturating at 0. The round SHALL end (enter KO next cycle) when either health==0 or round_timer==0 after that cycle's updates.
REQ-012 Round result SHALL be decided at the FIGHT->KO transition:
- Higher remaining health wins, and that player's round count increments by 1.
- Equal health (including double KO, or a timeout tie) is a draw; no count changes.
REQ-013 KO: SHALL freeze healths and round_timer, and count KO_TICKS ticks.
- If either round count == ROUNDS_TO_WIN, SHALL then go to MATCH_OVER with winner = 1 or 2.
- Otherwise SHALL go to COUNTDOWN, reloading healths to MAX_HEALTH and round_timer to ROUND_TICKS.
REQ-014 MATCH_OVER: SHALL hold all outputs. On start, SHALL behave as REQ-009 (new match).
REQ-015 start SHALL be ignored outside IDLE and MATCH_OVER. tick SHALL be ignored in IDLE and MATCH_OVER.
REQ-016 phase, fight_enable, winner and round counts SHALL be registered outputs with no combinational path from inputs.
REQ-017 Round counts SHALL never exceed ROUNDS_TO_WIN; only one count can increment per round.

Reset
REQ-018 On reset assertion, the block SHALL immediately, asynchronously and mid-operation, set:
- phase=IDLE, fight_enable=0, winner=0;
- healths=MAX_HEALTH, rounds=0, round_timer=ROUND_TICKS;
- all internal counters=0, and hit-edge history=0.
REQ-019 After reset release, the first hit SHALL be recognized only on a new rising edge of hitstun.

Verification
Common setup for all scenarios: COUNTDOWN_TICKS=3, ROUND_TICKS=10, KO_TICKS=2, tick tied high.
REQ-020 Start pulse -> phase 1 for 3 cycles, then phase 2 with fight_enable=1 and round_timer=10.
REQ-021 Three separate player2 hitstun entries in FIGHT -> player2_health 3,2,1,0; KO next cycle; player1_rounds=1. After 2 ticks, back in COUNTDOWN with both healths=3.
REQ-022 Player 1 wins two rounds -> phase 4 and winner=1. A further start pulse -> rounds=0 and phase 1.
REQ-023 Player1 takes one hit, then no hits until round_timer reaches 0 -> KO with player2_rounds+1. Same hit count on both sides at timeout -> draw with no count change.
REQ-024 Both players enter hitstun in the same cycle with health 1 each -> both healths 0, draw, counts unchanged. Hitstun held high across COUNTDOWN into FIGHT -> no decrement.
REQ-025 Reset asserted mid-FIGHT with health 2/1 -> outputs return to REQ-018 values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/round_controller.sv
// -----------------------------------------------------------------------------
// round_controller
//
// Match sequencer for a two-player fighting game. A match is a series of
// rounds: a pre-round countdown, a timed fight in which hits drain health, and
// a short post-round freeze. The round goes to the player with more health
// left. The first player to reach ROUNDS_TO_WIN round wins takes the match.
//
// Ports
//   clk             : the only clock
//   reset           : asynchronous, active-high reset
//   tick            : one-cycle frame strobe that advances all game timers
//   start           : one-cycle start-button pulse (honoured in IDLE/MATCH_OVER)
//   player1_status  : player 1 status code, 4'd9 means hitstun
//   player2_status  : player 2 status code, 4'd9 means hitstun
//   player1_health  : player 1 remaining health
//   player2_health  : player 2 remaining health
//   player1_rounds  : player 1 round wins
//   player2_rounds  : player 2 round wins
//   phase           : IDLE=0, COUNTDOWN=1, FIGHT=2, KO=3, MATCH_OVER=4
//   fight_enable    : high only while in FIGHT
//   round_timer     : remaining round ticks
//   winner          : 0 none, 1 player 1, 2 player 2, 3 draw
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module round_controller #(
  parameter logic [3:0]  MAX_HEALTH      = 4'd3,
  parameter int unsigned ROUNDS_TO_WIN   = 2,
  parameter int unsigned COUNTDOWN_TICKS = 180,
  parameter logic [11:0] ROUND_TICKS     = 12'd3600,
  parameter int unsigned KO_TICKS        = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic [3:0]  player1_status,
  input  logic [3:0]  player2_status,
  output logic [3:0]  player1_health,
  output logic [3:0]  player2_health,
  output logic [1:0]  player1_rounds,
  output logic [1:0]  player2_rounds,
  output logic [2:0]  phase,
  output logic        fight_enable,
  output logic [11:0] round_timer,
  output logic [1:0]  winner
);

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_COUNTDOWN  = 3'd1,
    PH_FIGHT      = 3'd2,
    PH_KO         = 3'd3,
    PH_MATCH_OVER = 3'd4
  } phase_e;

  localparam logic [3:0]  HITSTUN   = 4'd9;
  localparam logic [15:0] CD_LOAD   = 16'(COUNTDOWN_TICKS);
  localparam logic [15:0] KO_LOAD   = 16'(KO_TICKS);
  localparam logic [1:0]  WIN_COUNT = 2'(ROUNDS_TO_WIN);

  // Health never wraps below zero.
  function automatic logic [3:0] sat_dec_health(input logic [3:0] value);
    logic [3:0] result;
    if (value == 4'd0) begin
      result = 4'd0;
    end else begin
      result = value - 4'd1;
    end
    return result;
  endfunction

  // Round timer never wraps below zero.
  function automatic logic [11:0] sat_dec_timer(input logic [11:0] value);
    logic [11:0] result;
    if (value == 12'd0) begin
      result = 12'd0;
    end else begin
      result = value - 12'd1;
    end
    return result;
  endfunction

  phase_e      phase_r,    phase_s;
  logic [3:0]  health1_r,  health1_s;
  logic [3:0]  health2_r,  health2_s;
  logic [1:0]  rounds1_r,  rounds1_s;
  logic [1:0]  rounds2_r,  rounds2_s;
  logic [11:0] timer_r,    timer_s;
  logic [1:0]  winner_r,   winner_s;
  logic        fight_en_r, fight_en_s;
  // Shared by COUNTDOWN and KO; each phase reloads it on entry.
  logic [15:0] wait_cnt_r, wait_cnt_s;

  // Hitstun history is sampled every cycle regardless of phase, so a stun
  // that started before FIGHT never registers as a fresh hit inside FIGHT.
  logic        stun1_prev_r, stun2_prev_r;
  logic        stun1_s, stun2_s;
  logic        hit1_s, hit2_s;

  assign stun1_s = (player1_status == HITSTUN);
  assign stun2_s = (player2_status == HITSTUN);
  assign hit1_s  = stun1_s & ~stun1_prev_r;
  assign hit2_s  = stun2_s & ~stun2_prev_r;

  // Next-state, counter and result computation for the match sequencer.
  always_comb begin
    phase_s    = phase_r;
    health1_s  = health1_r;
    health2_s  = health2_r;
    rounds1_s  = rounds1_r;
    rounds2_s  = rounds2_r;
    timer_s    = timer_r;
    winner_s   = winner_r;
    wait_cnt_s = wait_cnt_r;

    case (phase_r)
      PH_IDLE, PH_MATCH_OVER: begin
        if (start) begin
          phase_s    = PH_COUNTDOWN;
          health1_s  = MAX_HEALTH;
          health2_s  = MAX_HEALTH;
          rounds1_s  = 2'd0;
          rounds2_s  = 2'd0;
          timer_s    = ROUND_TICKS;
          winner_s   = 2'd0;
          wait_cnt_s = CD_LOAD;
        end else begin
          phase_s = phase_r;
        end
      end

      PH_COUNTDOWN: begin
        health1_s = MAX_HEALTH;
        health2_s = MAX_HEALTH;
        timer_s   = ROUND_TICKS;
        if (tick) begin
          // The tick that uses up the last countdown count opens the fight.
          if (wait_cnt_r <= 16'd1) begin
            phase_s    = PH_FIGHT;
            wait_cnt_s = 16'd0;
          end else begin
            wait_cnt_s = wait_cnt_r - 16'd1;
          end
        end else begin
          wait_cnt_s = wait_cnt_r;
        end
      end

      PH_FIGHT: begin
        if (hit1_s) begin
          health1_s = sat_dec_health(health1_r);
        end else begin
          health1_s = health1_r;
        end
        if (hit2_s) begin
          health2_s = sat_dec_health(health2_r);
        end else begin
          health2_s = health2_r;
        end
        if (tick) begin
          timer_s = sat_dec_timer(timer_r);
        end else begin
          timer_s = timer_r;
        end
        // The round ends on this cycle's updated values, so a KO hit or the
        // last timer tick is reflected in the same edge that enters KO.
        if ((health1_s == 4'd0) || (health2_s == 4'd0) || (timer_s == 12'd0)) begin
          phase_s    = PH_KO;
          wait_cnt_s = KO_LOAD;
          if ((health1_s > health2_s) && (rounds1_r < WIN_COUNT)) begin
            rounds1_s = rounds1_r + 2'd1;
          end else if ((health2_s > health1_s) && (rounds2_r < WIN_COUNT)) begin
            rounds2_s = rounds2_r + 2'd1;
          end else begin
            // Equal health is a draw: nobody scores.
            rounds1_s = rounds1_r;
            rounds2_s = rounds2_r;
          end
        end else begin
          phase_s = PH_FIGHT;
        end
      end

      PH_KO: begin
        if (tick) begin
          if (wait_cnt_r <= 16'd1) begin
            wait_cnt_s = 16'd0;
            if (rounds1_r == WIN_COUNT) begin
              phase_s  = PH_MATCH_OVER;
              winner_s = 2'd1;
            end else if (rounds2_r == WIN_COUNT) begin
              phase_s  = PH_MATCH_OVER;
              winner_s = 2'd2;
            end else begin
              phase_s    = PH_COUNTDOWN;
              health1_s  = MAX_HEALTH;
              health2_s  = MAX_HEALTH;
              timer_s    = ROUND_TICKS;
              wait_cnt_s = CD_LOAD;
            end
          end else begin
            wait_cnt_s = wait_cnt_r - 16'd1;
          end
        end else begin
          wait_cnt_s = wait_cnt_r;
        end
      end

      default: begin
        phase_s    = PH_IDLE;
        wait_cnt_s = 16'd0;
      end
    endcase

    fight_en_s = (phase_s == PH_FIGHT);
  end

  // State, score and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r      <= PH_IDLE;
      health1_r    <= MAX_HEALTH;
      health2_r    <= MAX_HEALTH;
      rounds1_r    <= 2'd0;
      rounds2_r    <= 2'd0;
      timer_r      <= ROUND_TICKS;
      winner_r     <= 2'd0;
      fight_en_r   <= 1'b0;
      wait_cnt_r   <= 16'd0;
      stun1_prev_r <= 1'b0;
      stun2_prev_r <= 1'b0;
    end else begin
      phase_r      <= phase_s;
      health1_r    <= health1_s;
      health2_r    <= health2_s;
      rounds1_r    <= rounds1_s;
      rounds2_r    <= rounds2_s;
      timer_r      <= timer_s;
      winner_r     <= winner_s;
      fight_en_r   <= fight_en_s;
      wait_cnt_r   <= wait_cnt_s;
      stun1_prev_r <= stun1_s;
      stun2_prev_r <= stun2_s;
    end
  end

  assign phase          = phase_r;
  assign fight_enable   = fight_en_r;
  assign player1_health = health1_r;
  assign player2_health = health2_r;
  assign player1_rounds = rounds1_r;
  assign player2_rounds = rounds2_r;
  assign round_timer    = timer_r;
  assign winner         = winner_r;

endmodule

// File: tb/tb_round_controller.sv
// -----------------------------------------------------------------------------
// tb_round_controller
//
// Scoreboard bench for round_controller with short timers (countdown 3,
// round 10, KO 2). The driver applies one set of inputs per cycle on the
// falling edge, advances a game-level reference model and queues the outputs
// the model expects after the next rising edge. A separate monitor pops and
// compares each rising edge. Directed match scripts are followed by random play
// and asynchronous mid-match resets.
// -----------------------------------------------------------------------------
module tb_round_controller;

  localparam int MAXH = 3;
  localparam int RTW  = 2;
  localparam int CDT  = 3;
  localparam int RT   = 10;
  localparam int KOT  = 2;

  localparam int P_IDLE  = 0;
  localparam int P_CD    = 1;
  localparam int P_FIGHT = 2;
  localparam int P_KO    = 3;
  localparam int P_OVER  = 4;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        start;
  logic [3:0]  player1_status;
  logic [3:0]  player2_status;
  logic [3:0]  player1_health;
  logic [3:0]  player2_health;
  logic [1:0]  player1_rounds;
  logic [1:0]  player2_rounds;
  logic [2:0]  phase;
  logic        fight_enable;
  logic [11:0] round_timer;
  logic [1:0]  winner;

  round_controller #(
    .MAX_HEALTH      (4'd3),
    .ROUNDS_TO_WIN   (RTW),
    .COUNTDOWN_TICKS (CDT),
    .ROUND_TICKS     (12'd10),
    .KO_TICKS        (KOT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .start          (start),
    .player1_status (player1_status),
    .player2_status (player2_status),
    .player1_health (player1_health),
    .player2_health (player2_health),
    .player1_rounds (player1_rounds),
    .player2_rounds (player2_rounds),
    .phase          (phase),
    .fight_enable   (fight_enable),
    .round_timer    (round_timer),
    .winner         (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ph;
    logic        fe;
    logic [3:0]  h1;
    logic [3:0]  h2;
    logic [1:0]  r1;
    logic [1:0]  r2;
    logic [11:0] tm;
    logic [1:0]  w;
  } obs_t;

  obs_t exp_q[$];
  int   vectors;
  int   miscompares;

  // Reference model: a match described as hits taken and ticks elapsed.
  int m_phase, m_hits1, m_hits2, m_fticks, m_pticks, m_wins1, m_wins2, m_winner;
  bit m_prev1, m_prev2;

  function automatic int hp(input int hits);
    return (hits >= MAXH) ? 0 : MAXH - hits;
  endfunction

  function automatic void model_new_round();
    m_phase  = P_CD;
    m_pticks = 0;
    m_hits1  = 0;
    m_hits2  = 0;
    m_fticks = 0;
  endfunction

  function automatic void model_reset();
    model_new_round();
    m_phase  = P_IDLE;
    m_wins1  = 0;
    m_wins2  = 0;
    m_winner = 0;
    m_prev1  = 1'b0;
    m_prev2  = 1'b0;
  endfunction

  function automatic void model_step(input bit st, input bit tk,
                                     input logic [3:0] s1, input logic [3:0] s2);
    bit hit1, hit2;
    int a, b;
    hit1    = (s1 == 4'd9) && !m_prev1;
    hit2    = (s2 == 4'd9) && !m_prev2;
    m_prev1 = (s1 == 4'd9);
    m_prev2 = (s2 == 4'd9);
    if (m_phase == P_IDLE || m_phase == P_OVER) begin
      if (st) begin
        m_wins1  = 0;
        m_wins2  = 0;
        m_winner = 0;
        model_new_round();
      end
    end else if (m_phase == P_CD) begin
      if (tk) m_pticks++;
      if (m_pticks == CDT) m_phase = P_FIGHT;
    end else if (m_phase == P_FIGHT) begin
      if (hit1) m_hits1++;
      if (hit2) m_hits2++;
      if (tk && m_fticks < RT) m_fticks++;
      a = hp(m_hits1);
      b = hp(m_hits2);
      if (a == 0 || b == 0 || m_fticks == RT) begin
        if (a > b) m_wins1++;
        else if (b > a) m_wins2++;
        m_phase  = P_KO;
        m_pticks = 0;
      end
    end else begin
      if (tk) m_pticks++;
      if (m_pticks == KOT) begin
        if (m_wins1 == RTW) begin
          m_phase  = P_OVER;
          m_winner = 1;
        end else if (m_wins2 == RTW) begin
          m_phase  = P_OVER;
          m_winner = 2;
        end else begin
          model_new_round();
        end
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.ph = 3'(m_phase);
    o.fe = (m_phase == P_FIGHT);
    o.h1 = 4'(hp(m_hits1));
    o.h2 = 4'(hp(m_hits2));
    o.r1 = 2'(m_wins1);
    o.r2 = 2'(m_wins2);
    o.tm = 12'(RT - m_fticks);
    o.w  = 2'(m_winner);
    return o;
  endfunction

  function automatic obs_t sample_dut();
    return {phase, fight_enable, player1_health, player2_health,
            player1_rounds, player2_rounds, round_timer, winner};
  endfunction

  task automatic report(input string name, input obs_t a, input obs_t e);
    $display("FAIL %s t=%0t got ph=%0d fe=%0d h1=%0d h2=%0d r1=%0d r2=%0d tm=%0d w=%0d expected ph=%0d fe=%0d h1=%0d h2=%0d r1=%0d r2=%0d tm=%0d w=%0d",
             name, $time, a.ph, a.fe, a.h1, a.h2, a.r1, a.r2, a.tm, a.w,
             e.ph, e.fe, e.h1, e.h2, e.r1, e.r2, e.tm, e.w);
  endtask

  // One cycle of stimulus: drive on the falling edge, queue the expectation.
  task automatic drive(input bit st, input bit tk,
                       input logic [3:0] s1, input logic [3:0] s2);
    @(negedge clk);
    start          = st;
    tick           = tk;
    player1_status = s1;
    player2_status = s2;
    model_step(st, tk, s1, s2);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 4'd0, 4'd0);
  endtask

  task automatic check_reset_values(input string name);
    obs_t a_v, e_v;
    e_v = '{ph:3'd0, fe:1'b0, h1:4'd3, h2:4'd3, r1:2'd0, r2:2'd0, tm:12'd10, w:2'd0};
    a_v = sample_dut();
    vectors++;
    if (a_v !== e_v) begin
      miscompares++;
      report(name, a_v, e_v);
    end
  endtask

  // Reset between clock edges; outputs must change before any edge arrives.
  task automatic async_reset_midrun();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("reset_async");
    start          = 1'b0;
    tick           = 1'b1;
    player1_status = 4'd0;
    player2_status = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset_held");
    reset = 1'b0;
  endtask

  // From COUNTDOWN: player 2 takes three separate hits and loses the round.
  task automatic p1_wins_round();
    idle(3);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 4'd0, 4'd9);
      drive(1'b0, 1'b1, 4'd0, 4'd0);
    end
    idle(1);
  endtask

  function automatic logic [3:0] pick_status();
    int r;
    r = $urandom_range(0, 3);
    if (r < 2) return 4'd9;
    else if (r == 2) return 4'd0;
    else return 4'($urandom_range(0, 15));
  endfunction

  // Monitor: compare the DUT against each queued expectation after the edge.
  initial begin
    obs_t e_v, a_v;
    forever begin
      @(posedge clk);
      #2;
      if (!reset && exp_q.size() > 0) begin
        e_v = exp_q.pop_front();
        a_v = sample_dut();
        vectors++;
        if (a_v !== e_v) begin
          miscompares++;
          report("scoreboard", a_v, e_v);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    bit         st, tk;
    logic [3:0] s1, s2;
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    start          = 1'b0;
    tick           = 1'b1;
    player1_status = 4'd0;
    player2_status = 4'd0;
    model_reset();
    #2;
    check_reset_values("reset_initial");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // IDLE ignores ticks and hits.
    idle(2);
    drive(1'b0, 1'b1, 4'd9, 4'd9);
    idle(1);

    // Player 1 takes a two-round match; the match then holds until start.
    drive(1'b1, 1'b1, 4'd0, 4'd0);
    p1_wins_round();
    p1_wins_round();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'd9, 4'd0);
    drive(1'b1, 1'b1, 4'd0, 4'd0);

    // Timeout with player 1 hit once: player 2 takes the round.
    idle(3);
    drive(1'b0, 1'b1, 4'd9, 4'd0);
    idle(9);
    idle(2);
    // Timeout with one hit each: draw.
    idle(3);
    drive(1'b0, 1'b1, 4'd9, 4'd0);
    drive(1'b0, 1'b1, 4'd0, 4'd9);
    idle(8);
    idle(2);
    // Simultaneous hits down to a double KO: draw.
    idle(3);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 4'd9, 4'd9);
      drive(1'b0, 1'b1, 4'd0, 4'd0);
    end
    drive(1'b0, 1'b1, 4'd9, 4'd9);
    idle(2);
    // Hitstun held from countdown into the fight never counts as a hit.
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 4'd9, 4'd9);
    idle(6);
    idle(2);

    // Random play, with tick gaps and stray start pulses.
    for (int i = 0; i < 1500; i++) begin
      st = ($urandom_range(0, 9) == 0);
      tk = ($urandom_range(0, 7) != 0);
      s1 = pick_status();
      s2 = pick_status();
      drive(st, tk, s1, s2);
      if (i == 700) async_reset_midrun();
    end

    // Reset in the middle of a fight with health 2/1.
    async_reset_midrun();
    drive(1'b1, 1'b1, 4'd0, 4'd0);
    idle(3);
    drive(1'b0, 1'b1, 4'd9, 4'd9);
    drive(1'b0, 1'b1, 4'd0, 4'd0);
    drive(1'b0, 1'b1, 4'd0, 4'd9);
    async_reset_midrun();
    // After reset, a hitstun that is already held is not a new hit.
    drive(1'b1, 1'b1, 4'd9, 4'd9);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 4'd9, 4'd9);
    idle(2);

    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
